// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI link definitions: opcodes and the frame state encoding
// used by both the master controller and the slave FSM.
package spi_master_ctrl_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TURN  = 3'd3,
        ST_READ  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_master_ctrl_shift_cnt.sv
// Loadable down-counter with terminal-count flag; times every
// multi-cycle phase of an SPI frame.
module spi_shift_cnt
    import spi_master_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises 10-bit host commands MSB-first and returns
// the read-back byte of rd-data frames with a one-cycle strobe.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CMD_W    = 10,
    parameter int DATA_W   = 8,
    parameter int TURN_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic              SCK,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              MOSI,
    output logic              SS_n,
    input  logic              MISO
);

    state_t             state;
    logic [CMD_W-1:0]   sh;
    logic [1:0]         op;
    logic [DATA_W-2:0]  rx;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_en;
    logic               cnt_tc;

    // Reload the phase timer on the edge that enters each timed state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state)
            ST_START: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(CMD_W - 1);
            end
            ST_SHIFT: begin
                cnt_load = cnt_tc;
                cnt_val  = (op == OP_RD_DATA) ? CNT_W'(TURN_CYC - 1)
                                              : CNT_W'(GAP_CYC - 1);
            end
            ST_TURN: begin
                cnt_load = cnt_tc;
                cnt_val  = CNT_W'(DATA_W - 1);
            end
            ST_READ: begin
                cnt_load = cnt_tc;
                cnt_val  = CNT_W'(GAP_CYC - 1);
            end
            default: begin
                cnt_load = 1'b0;
                cnt_val  = '0;
            end
        endcase
    end

    assign cnt_en = (state == ST_SHIFT) || (state == ST_TURN) ||
                    (state == ST_READ)  || (state == ST_STOP);

    spi_shift_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (SCK),
        .rst_n    (rstn),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    always_ff @(posedge SCK) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            sh        <= '0;
            op        <= '0;
            rx        <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        sh        <= cmd_data;
                        op        <= cmd_data[CMD_W-1 -: 2];
                        MOSI      <= cmd_data[CMD_W-1];
                        SS_n      <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                // Command-check bit is sent twice: in START and SHIFT bit 0.
                ST_START: begin
                    MOSI  <= sh[CMD_W-1];
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_tc) begin
                        MOSI <= 1'b0;
                        if (op == OP_RD_DATA) begin
                            state <= ST_TURN;
                        end else begin
                            SS_n  <= 1'b1;
                            state <= ST_STOP;
                        end
                    end else begin
                        MOSI <= sh[CMD_W-2];
                        sh   <= {sh[CMD_W-2:0], 1'b0};
                    end
                end
                ST_TURN: begin
                    if (cnt_tc) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    rx <= {rx[DATA_W-3:0], MISO};
                    if (cnt_tc) begin
                        rsp_data  <= {rx, MISO};
                        rsp_valid <= 1'b1;
                        SS_n      <= 1'b1;
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_tc) begin
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: behavioural SPI slave + RAM model on the
// far side of the link and a response scoreboard on the host side.
module tb_spi_master_ctrl;

    logic       SCK = 1'b0;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       MOSI;
    logic       SS_n;
    logic       MISO;

    int checks = 0;
    int errors = 0;
    int rsp_cnt = 0;

    logic [7:0] exp_q[$];
    logic [9:0] word_q[$];
    int         len_q[$];
    logic       start_q[$];

    int         idx = 0;
    int         gap_cnt = 0;
    int         min_gap = 1000;
    bit         seen_frame = 0;
    logic [9:0] rxw = '0;
    logic [7:0] mem [256];
    logic [7:0] s_addr = '0;
    logic [7:0] rd_byte = '0;
    logic       miso_idle = 1'b0;

    spi_master_ctrl dut (
        .SCK       (SCK),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .MISO      (MISO)
    );

    always #5 SCK = ~SCK;

    // Slave + RAM model: frame index 0 is the check bit, 1..10 the
    // command, 11..12 turnaround, 13..20 the read-back byte.
    always @(negedge SCK) begin
        if (SS_n !== 1'b0) begin
            if (idx > 0) begin
                len_q.push_back(idx);
                idx = 0;
                seen_frame = 1;
                gap_cnt = 0;
            end
            gap_cnt++;
            MISO = miso_idle;
            if (rstn === 1'b1) begin
                checks++;
                if (MOSI !== 1'b0) begin
                    errors++;
                    $display("FAIL mosi_idle: got %b want 0 at %0t", MOSI, $time);
                end
            end
        end else begin
            if (idx == 0) begin
                start_q.push_back(MOSI);
                if (seen_frame && gap_cnt < min_gap) min_gap = gap_cnt;
            end else if (idx <= 10) begin
                rxw = {rxw[8:0], MOSI};
            end
            if (idx == 10) begin
                word_q.push_back(rxw);
                case (rxw[9:8])
                    2'b00: s_addr = rxw[7:0];
                    2'b01: mem[s_addr] = rxw[7:0];
                    2'b10: s_addr = rxw[7:0];
                    default: rd_byte = mem[s_addr];
                endcase
            end
            MISO = (idx >= 13 && idx <= 20) ? rd_byte[20-idx] : miso_idle;
            idx++;
        end
    end

    // Response scoreboard and ready/idle consistency monitor.
    always @(negedge SCK) begin
        if (rstn === 1'b1) begin
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %h want none", rsp_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rsp_data !== e) begin
                        errors++;
                        $display("FAIL rsp_data: got %h want %h", rsp_data, e);
                    end
                end
            end
            if (cmd_ready === 1'b1) begin
                checks++;
                if (busy !== 1'b0 || SS_n !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_idle: busy=%b SS_n=%b want 0/1", busy, SS_n);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        word_q.delete();
        len_q.delete();
        start_q.delete();
        min_gap = 1000;
    endtask

    task automatic send(input logic [9:0] w, input bit exp_rsp,
                        input logic [7:0] b);
        int n = 0;
        @(negedge SCK);
        cmd_valid = 1'b1;
        cmd_data = w;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge SCK);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: cmd %h not accepted", w);
            cmd_valid = 1'b0;
            return;
        end
        if (exp_rsp) exp_q.push_back(b);
        @(posedge SCK);
        #1;
        cmd_valid = 1'b0;
        cmd_data = 10'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge SCK);
            n++;
        end while ((busy !== 1'b0 || SS_n !== 1'b1) && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b SS_n=%b", busy, SS_n);
        end
        repeat (2) @(negedge SCK);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = '0;
        MISO = 1'b0;
        repeat (3) begin
            @(negedge SCK);
            checks++;
            if (SS_n !== 1 || rsp_valid !== 0 || cmd_ready !== 0 ||
                busy !== 0 || MOSI !== 0 || rsp_data !== 0) begin
                errors++;
                $display("FAIL reset_vals: SS_n=%b rv=%b rdy=%b busy=%b mosi=%b rd=%h",
                         SS_n, rsp_valid, cmd_ready, busy, MOSI, rsp_data);
            end
        end
        rstn = 1'b1;
        @(negedge SCK);
        checks++;
        if (cmd_ready !== 1 || SS_n !== 1 || rsp_valid !== 0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b SS_n=%b rv=%b want 1/1/0",
                     cmd_ready, SS_n, rsp_valid);
        end
    endtask

    task automatic test_write_addr();
        int r0 = rsp_cnt;
        clear_q();
        send(10'h0A5, 0, 8'h00);
        wait_idle();
        checks++;
        if (len_q.size() != 1 || len_q[0] != 11) begin
            errors++;
            $display("FAIL wa_len: got n=%0d len=%0d want 11", len_q.size(), len_q[0]);
        end
        checks++;
        if (start_q.size() != 1 || start_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL wa_start: got %b want 0", start_q[0]);
        end
        checks++;
        if (word_q.size() != 1 || word_q[0] !== 10'h0A5) begin
            errors++;
            $display("FAIL wa_word: got %h want 0a5", word_q[0]);
        end
        checks++;
        if (rsp_cnt != r0) begin
            errors++;
            $display("FAIL wa_norsp: got %0d pulses want 0", rsp_cnt - r0);
        end
    endtask

    task automatic test_write_read();
        logic [9:0] w [4];
        int         l [4];
        int         r0 = rsp_cnt;
        w = '{10'h01F, 10'h1C3, 10'h21F, 10'h300};
        l = '{11, 11, 11, 21};
        clear_q();
        for (int i = 0; i < 4; i++) send(w[i], i == 3, 8'hC3);
        wait_idle();
        checks++;
        if (rsp_cnt - r0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wr_rsp_count: got %0d pending=%0d want 1/0",
                     rsp_cnt - r0, exp_q.size());
        end
        checks++;
        if (rsp_data !== 8'hC3) begin
            errors++;
            $display("FAIL wr_rsp_hold: got %h want c3", rsp_data);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (word_q.size() != 4 || len_q.size() != 4 ||
                word_q[i] !== w[i] || len_q[i] != l[i] || start_q[i] !== w[i][9]) begin
                errors++;
                $display("FAIL wr_frame%0d: got w=%h len=%0d want w=%h len=%0d",
                         i, word_q[i], len_q[i], w[i], l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w [3];
        w = '{10'h055, 10'h16A, 10'h0C3};
        clear_q();
        @(negedge SCK);
        cmd_valid = 1'b1;
        cmd_data = w[0];
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            while (cmd_ready !== 1'b1 && n < 200) begin
                @(negedge SCK);
                n++;
            end
            checks++;
            if (n >= 200 || busy !== 1'b0 || SS_n !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept%0d: n=%0d busy=%b SS_n=%b", i, n, busy, SS_n);
            end
            @(posedge SCK);
            #1;
            if (i < 2) cmd_data = w[i+1];
            else cmd_valid = 1'b0;
        end
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (word_q.size() != 3 || word_q[i] !== w[i] || len_q[i] != 11) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h len=%0d want %h len=11",
                         i, word_q[i], len_q[i], w[i]);
            end
        end
        checks++;
        if (min_gap < 1 || min_gap == 1000) begin
            errors++;
            $display("FAIL b2b_gap: got %0d want >=1", min_gap);
        end
    endtask

    task automatic test_miso_isolation();
        int r0 = rsp_cnt;
        miso_idle = 1'b1;
        clear_q();
        send(10'h040, 0, 8'h00);
        send(10'h15A, 0, 8'h00);
        send(10'h240, 0, 8'h00);
        send(10'h300, 1, 8'h5A);
        wait_idle();
        checks++;
        if (rsp_data !== 8'h5A || rsp_cnt - r0 != 1) begin
            errors++;
            $display("FAIL iso_ones: got %h pulses=%0d want 5a/1", rsp_data, rsp_cnt - r0);
        end
        checks++;
        if (len_q.size() != 4 || len_q[3] != 21) begin
            errors++;
            $display("FAIL iso_len: got %0d want 21", len_q[3]);
        end
        miso_idle = 1'bx;
        send(10'h300, 1, 8'h5A);
        wait_idle();
        checks++;
        if (rsp_data !== 8'h5A || rsp_cnt - r0 != 2) begin
            errors++;
            $display("FAIL iso_x: got %h pulses=%0d want 5a/2", rsp_data, rsp_cnt - r0);
        end
        miso_idle = 1'b0;
    endtask

    task automatic test_mid_reset();
        int r0 = rsp_cnt;
        int n = 0;
        clear_q();
        @(negedge SCK);
        cmd_valid = 1'b1;
        cmd_data = 10'h3AB;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge SCK);
            n++;
        end
        @(posedge SCK);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(negedge SCK);
        checks++;
        if (SS_n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mr_inframe: SS_n=%b busy=%b want 0/1", SS_n, busy);
        end
        rstn = 1'b0;
        @(negedge SCK);
        checks++;
        if (SS_n !== 1 || rsp_valid !== 0 || rsp_data !== 0 || busy !== 0 || cmd_ready !== 0) begin
            errors++;
            $display("FAIL mr_abort: SS_n=%b rv=%b rd=%h busy=%b rdy=%b",
                     SS_n, rsp_valid, rsp_data, busy, cmd_ready);
        end
        rstn = 1'b1;
        repeat (30) @(negedge SCK);
        checks++;
        if (rsp_cnt != r0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL mr_norsp: pulses=%0d rd=%h want 0/00", rsp_cnt - r0, rsp_data);
        end
        clear_q();
        send(10'h0A5, 0, 8'h00);
        wait_idle();
        checks++;
        if (len_q.size() != 1 || len_q[0] != 11 || word_q.size() != 1 || word_q[0] !== 10'h0A5) begin
            errors++;
            $display("FAIL mr_next: got len=%0d w=%h want 11/0a5", len_q[0], word_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_read();
        test_back_to_back();
        test_miso_isolation();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_missing: %0d responses never arrived", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Upstream stage for the SPI slave + RAM interface; generates its MOSI and SS_n and consumes its MISO.
- Accepts 10-bit command words from a host over a valid/ready handshake and serialises each word MSB-first, one frame per word.
- For read-data commands (bits[9:8]=2'b11), captures the 8-bit byte returned on MISO and presents it with a one-cycle response strobe.
- Shares SCK with the slave and RAM, so the whole link is single-clock.

Parameters:
- CMD_W, 10, command word width; bits[9:8] are the opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data) and bits[7:0] are the payload.
- DATA_W, 8, read-back byte width.
- TURN_CYC, 2, idle cycles between the last MOSI bit and the first MISO sample on a read-data frame (1..7).
- GAP_CYC, 1, minimum cycles SS_n is held high between frames (1..7).

Ports:
- SCK  input  1  system/SPI clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset.
- cmd_valid  input  1  host presents cmd_data.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_data  input  CMD_W  command word.
- rsp_valid  output  1  one-cycle strobe: rsp_data holds a read-back byte.
- rsp_data  output  DATA_W  read-back byte, held until the next read completes.
- busy  output  1  frame in progress (any state other than IDLE).
- MOSI  output  1  serial data to the slave.
- SS_n  output  1  active-low slave select.
- MISO  input  1  serial data from the slave.

Behaviour:
- One clock (SCK); reset is synchronous and active-low (rstn).
- All outputs are registered.
- Reset (rstn=0 at a posedge) aborts any frame in progress, with no partial response. Reset values: SS_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE, counters=0.
- cmd_ready rises the cycle after rstn is released.
- Handshake: a command is accepted on a posedge where cmd_valid&&cmd_ready. The word is latched into a shift register and cmd_ready drops the next cycle. cmd_data is ignored at all other times.
- cmd_ready=1 only in IDLE. There is no queueing: back-to-back commands wait out the frame and the gap.
- FSM states: IDLE, START, SHIFT, TURN, READ, STOP.
- IDLE: SS_n=1. On accept, go to START.
- START (1 cycle): SS_n=0, MOSI=word[9] (the command-check bit). Go to SHIFT.
- SHIFT (exactly CMD_W cycles): MOSI=word[9], then word[8], down to word[0], one bit per cycle; a bit counter runs 0..CMD_W-1. On count CMD_W-1, go to TURN if opcode==2'b11, else to STOP.
- TURN (TURN_CYC cycles): SS_n=0, MOSI=0. Go to READ.
- READ (DATA_W cycles): sample MISO each posedge into rx_shift, MSB first. After the DATA_W-th sample:
  - rsp_data <= the assembled byte;
  - rsp_valid=1 for exactly 1 cycle, coincident with entry to STOP.
- STOP (GAP_CYC cycles): SS_n=1, MOSI=0. Go to IDLE; cmd_ready=1 in the first IDLE cycle.
- Frame length with SS_n low: 1+CMD_W cycles for opcodes 00/01/10, and 1+CMD_W+TURN_CYC+DATA_W for opcode 11.
- Accept-to-SS_n-low latency: 1 cycle.
- Last-MISO-sample-to-rsp_valid latency: 1 cycle.
- MISO is ignored outside READ. X on MISO outside READ must not reach rsp_data.
- busy = (state != IDLE).
- cmd_valid deasserting mid-frame has no effect.
- rstn low in any state returns to IDLE at that posedge, with SS_n high on the following cycle.

Decomposition:
- Shared package holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - the state encoding (3-bit: IDLE=0 .. STOP=5), used by the slave FSM and this block alike.
- One sub-module is natural: spi_shift_cnt, a loadable down-counter with a terminal-count flag, reused for the SHIFT, TURN, READ and STOP durations.
- Everything else lives in the top FSM.

Test Plan:
- Reset release: rstn low 3 cycles, then high -> cycle after release cmd_ready=1; SS_n=1, rsp_valid=0 throughout.
- Write address: send cmd 10'h0A5 (opcode 00) -> SS_n low 11 cycles; MOSI sequence 0, then 0,0,1,0,1,0,0,1,0,1; SS_n high for GAP_CYC; no rsp_valid.
- Full write/read via the interface model:
  - sequence: 10'h01F (wr-addr 0x1F), 10'h1C3 (wr-data 0xC3), 10'h21F (rd-addr 0x1F), 10'h300 (rd-data);
  - required response: one rsp_valid pulse with rsp_data=8'hC3;
  - rd-data frame has SS_n low 1+10+TURN_CYC+8 cycles.
- Back-pressure: cmd_valid held high with three queued words -> each accepted only in IDLE; SS_n high for at least GAP_CYC between frames; words on MOSI in order.
- Mid-frame reset: assert rstn low during SHIFT bit 4 of a rd-data frame -> SS_n=1 the next cycle, no rsp_valid, rsp_data stays 0; the next command completes normally.
- MISO isolation: drive MISO=1 outside READ during a rd-data frame while the slave returns 8'h5A -> rsp_data=8'h5A.
